bb_playback_ctrl: RTL

BB_PLAYBACK_CTRL -- requirements
Module: bb_playback_ctrl

---
 rtl/bb_playback_pkg.sv | 16 +
 rtl/bb_sample_fifo.sv | 58 +++++
 rtl/bb_playback_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bb_playback_pkg.sv
// Shared types and default sizes for the playback controller.
// Optional stall statistics are enabled with the BB_PLAYBACK_STATS_EN macro.
package bb_playback_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_CNT_WIDTH  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bb_state_e;

endpackage

// File: rtl/bb_sample_fifo.sv
// First-word fall-through sample buffer: head is visible whenever not empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module bb_sample_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   head_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [AW:0]           count_q;
  logic                  do_push;
  logic                  do_pop;

  // Guarded so a misbehaving upstream can never corrupt the pointers.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/bb_playback_ctrl.sv
// Playback controller: pulls samples from a file-reader source into a small
// FWFT buffer for a downstream consumer. BB_PLAYBACK_STATS_EN adds stall_cycles.
module bb_playback_ctrl
  import bb_playback_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [CNT_WIDTH-1:0]  num_samples,
  output logic                  src_run,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output logic                  eof,
`ifdef BB_PLAYBACK_STATS_EN
  output logic [CNT_WIDTH-1:0]  stall_cycles,
`endif
  output bb_state_e             state_dbg
);

  // Handshakes: src_run issues one read whose answer (src_valid/src_data)
  // arrives exactly one cycle later; the output side transfers a sample on
  // every cycle where out_valid and out_ready are both high.

  localparam int AW = $clog2(FIFO_DEPTH);

  bb_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [CNT_WIDTH-1:0]  issued_q, issued_d;
  logic                  inflight_q;
  logic                  eof_q, eof_d;

  logic [AW:0]           fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  dry;
  logic                  room;
  logic                  drain_done;
  logic [AW+1:0]         pending;

  assign push    = inflight_q && src_valid;
  assign dry     = inflight_q && !src_valid;
  assign pop     = out_valid && out_ready;
  assign pending = {1'b0, fifo_count} + {{(AW+1){1'b0}}, inflight_q};
  assign room    = !fifo_full && (pending < (AW+2)'(FIFO_DEPTH));

  // Finish as soon as the buffer empties, so done follows the last pop directly.
  assign drain_done = !inflight_q &&
                      (fifo_empty || ((fifo_count == (AW+1)'(1)) && pop));

  bb_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (src_data),
    .pop       (pop),
    .head_data (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      num_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      eof_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      inflight_q <= src_run;
      eof_q      <= eof_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    issued_d = issued_q;
    eof_d    = eof_q;
    src_run  = 1'b0;
    done     = 1'b0;
    if (dry) eof_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d    = num_samples;
          issued_d = '0;
          eof_d    = 1'b0;
          state_d  = (num_samples == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        src_run = (issued_q < num_q) && room && !stop && !dry;
        if (src_run) issued_d = issued_q + 1'b1;
        if (stop || dry || (issued_q == num_q)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_valid = !fifo_empty;
  assign busy      = (state_q != ST_IDLE);
  assign eof       = eof_q;
  assign state_dbg = state_q;

`ifdef BB_PLAYBACK_STATS_EN
  logic [CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset || ((state_q == ST_IDLE) && start)) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule
